lfsr_prn_arbiter: RTL and testbench
===================================

// Module: lfsr_prn_arbiter
// PURPOSE
//  Shares one free-running Fibonacci LFSR (lfsr: clk, reset, lfsr_enable, prn) among N_REQ requesters.
//  Sequences the LFSR: warm-up after reset, one single-step advance per grant, stuck/zero detection.
//  Every PRN word reaches exactly one requester; no word is issued twice between faults/resets.
//  Sits between the lfsr instance and its consumers; owns the lfsr_enable pin.
// PARAMETERS
//  WIDTH          16  PRN word width; must match the lfsr instance.
//  N_REQ          4   number of requesters (2..8).
//  WARMUP_CYCLES  32  LFSR steps after reset before the first grant (>=1).
// PORTS
//  clk          in   1            rising-edge clock.
//  reset        in   1            synchronous, active-high.
//  req          in   N_REQ        req[i] high = requester i wants one word; held until ack[i].
//  ack          out  N_REQ        one-hot, one-cycle pulse; word valid on prn_out that cycle.
//  prn_out      out  WIDTH        word for the acked requester; holds last value otherwise.
//  ready        out  1            high in IDLE (arbiter can accept a grant this cycle).
//  lfsr_fault   out  1            sticky; LFSR read 0 or failed to change after a step.
//  grant_count  out  16           total grants since reset; wraps 0xFFFF->0x0000.
//  lfsr_enable  out  1            to lfsr; registered; one step per high cycle.
//  prn          in   WIDTH        from lfsr; updates on the edge ending a lfsr_enable-high cycle.
// BEHAVIOUR
//  Reset (sync, high): state=WARMUP, ack=0, prn_out=0, ready=0, lfsr_fault=0, grant_count=0,
//   lfsr_enable=0, rr_ptr=0, warm_cnt=0. Reset mid-operation aborts any pending grant; no ack is issued.
//  States: WARMUP, IDLE, STEP, SETTLE, FAULT.
//  WARMUP: lfsr_enable=1 for exactly WARMUP_CYCLES cycles (warm_cnt counts to WARMUP_CYCLES-1),
//   then lfsr_enable=0 and ->SETTLE with snap=0 check disabled (only prn!=0 is checked).
//  IDLE: ready=1. If |req: winner = first set bit at or after rr_ptr (circular).
//   Registered at that edge: ack<=onehot(winner), prn_out<=prn, snap<=prn, lfsr_enable<=1,
//   rr_ptr<=winner+1 mod N_REQ, grant_count<=grant_count+1; ->STEP. No req: stay, ack=0.
//  STEP: ack=0, lfsr_enable drops to 0 at the end of this cycle (exactly one step); ->SETTLE.
//  SETTLE: prn now updated. If prn==0 or prn==snap: lfsr_fault<=1, ->FAULT. Else ->IDLE.
//  FAULT: ready=0, ack=0, lfsr_enable=0, absorbing until reset.
//  Throughput: at most one grant per 3 cycles (IDLE->STEP->SETTLE->IDLE); ack appears 1 cycle
//   after the IDLE cycle in which req was sampled.
//  Requester dropping req before ack: request is lost, no ack; legal.
//  Requester holding req after ack: treated as a new request; round-robin prevents starvation:
//   any continuously requesting i is acked within N_REQ grants.
//  Only one ack bit ever high; ack never high outside the cycle after IDLE.
//  rr_ptr wraps N_REQ-1 -> 0; grant_count wraps silently.
// STRUCTURE
//  Shared package lfsr_pkg: state encoding (localparams ST_WARMUP..ST_FAULT), default WIDTH=16,
//   grant-counter width 16.
//  One sub-module: rr_arbiter (req, rr_ptr -> onehot winner, winner index, any); pure combinational.
//  FSM, counters, snap register and output registers live in lfsr_prn_arbiter. lfsr is instantiated
//   by the parent, not here.
// TESTING (WIDTH=16, N_REQ=4, WARMUP_CYCLES=32, real lfsr instance)
//  1 Reset 3 cycles, no req -> lfsr_enable high exactly 32 cycles, ready rises at cycle 34, fault=0.
//  2 req=4'b0001 held -> ack[0] every 3 cycles, successive prn_out distinct, grant_count 1,2,3...
//  3 req=4'b1111 held -> ack order 0,1,2,3,0...; 400 grants, no prn_out value repeated.
//  4 Stub lfsr with prn stuck at 16'hACE1 -> after first grant, lfsr_fault=1, ready=0, no further ack.
//  5 Stub lfsr forced to 0 during warm-up -> lfsr_fault=1 at end of warm-up, zero acks.
//  6 Assert reset in STEP cycle -> no ack, grant_count=0, warm-up restarts (32 enable cycles).

Source files
------------

// File: rtl/lfsr_prn_arbiter_pkg.sv
// lfsr_pkg: shared state encoding and widths for the LFSR PRN arbiter
package lfsr_pkg;
  localparam int WIDTH_DEF = 16;
  localparam int GC_W = 16;
  typedef enum logic [2:0] {
    ST_WARMUP,
    ST_IDLE,
    ST_STEP,
    ST_SETTLE,
    ST_FAULT
  } state_e;
endpackage

// File: rtl/lfsr_prn_arbiter_if.sv
// lfsr_prn_arbiter_if: requester handshake plus LFSR enable/word between arbiter and its environment
interface lfsr_prn_arbiter_if
  import lfsr_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] ack;
  logic [WIDTH-1:0] prn_out;
  logic [WIDTH-1:0] prn;
  logic ready;
  logic lfsr_fault;
  logic lfsr_enable;
  logic [GC_W-1:0] grant_count;
  modport master (
    output req, prn,
    input ack, prn_out, ready, lfsr_fault, grant_count, lfsr_enable
  );
  modport slave (
    input req, prn,
    output ack, prn_out, ready, lfsr_fault, grant_count, lfsr_enable
  );
endinterface

// File: rtl/lfsr_prn_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr_i
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] onehot_o,
  output logic [IW-1:0]    idx_o,
  output logic             any_o
);
  logic [IW:0] j;
  // Scan from the farthest offset down so the nearest request after ptr_i wins.
  always_comb begin
    idx_o = '0;
    j = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = (IW+1)'(ptr_i) + (IW+1)'(k);
      j = (j >= (IW+1)'(N_REQ)) ? j - (IW+1)'(N_REQ) : j;
      idx_o = req_i[j[IW-1:0]] ? j[IW-1:0] : idx_o;
    end
  end
  assign any_o = |req_i;
  assign onehot_o = any_o ? (N_REQ)'(1) << idx_o : '0;
endmodule

// File: rtl/lfsr_prn_arbiter.sv
// lfsr_prn_arbiter: sequences a shared LFSR and hands each PRN word to exactly one requester
module lfsr_prn_arbiter
  import lfsr_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int N_REQ = 4,
  parameter int WARMUP_CYCLES = 32
) (
  input logic clk,
  input logic reset,
  lfsr_prn_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int WW = $clog2(WARMUP_CYCLES + 1);
  state_e state_q, state_d;
  logic [N_REQ-1:0] ack_q, ack_d, win_oh;
  logic [WIDTH-1:0] prn_out_q, prn_out_d, snap_q, snap_d;
  logic en_q, en_d, fault_q, fault_d, win_any;
  logic [GC_W-1:0] gc_q, gc_d;
  logic [IW-1:0] rr_q, rr_d, win_idx;
  logic [WW-1:0] warm_q, warm_d;
  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req_i(bus.req),
    .ptr_i(rr_q),
    .onehot_o(win_oh),
    .idx_o(win_idx),
    .any_o(win_any)
  );
  // snap stays 0 through warm-up, so the first settle check reduces to prn != 0.
  always_comb begin
    state_d = state_q;
    ack_d = '0;
    prn_out_d = prn_out_q;
    snap_d = snap_q;
    en_d = 1'b0;
    fault_d = fault_q;
    gc_d = gc_q;
    rr_d = rr_q;
    warm_d = warm_q;
    case (state_q)
      ST_WARMUP: begin
        en_d = !(en_q && warm_q == WW'(WARMUP_CYCLES - 1));
        warm_d = en_q ? warm_q + 1'b1 : warm_q;
        state_d = en_d ? ST_WARMUP : ST_SETTLE;
      end
      ST_IDLE: if (win_any) begin
        ack_d = win_oh;
        prn_out_d = bus.prn;
        snap_d = bus.prn;
        en_d = 1'b1;
        rr_d = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
        gc_d = gc_q + 1'b1;
        state_d = ST_STEP;
      end
      ST_STEP: state_d = ST_SETTLE;
      ST_SETTLE: begin
        fault_d = (bus.prn == '0) || (bus.prn == snap_q);
        state_d = fault_d ? ST_FAULT : ST_IDLE;
      end
      default: state_d = ST_FAULT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_WARMUP;
      ack_q <= '0;
      prn_out_q <= '0;
      snap_q <= '0;
      en_q <= 1'b0;
      fault_q <= 1'b0;
      gc_q <= '0;
      rr_q <= '0;
      warm_q <= '0;
    end else begin
      state_q <= state_d;
      ack_q <= ack_d;
      prn_out_q <= prn_out_d;
      snap_q <= snap_d;
      en_q <= en_d;
      fault_q <= fault_d;
      gc_q <= gc_d;
      rr_q <= rr_d;
      warm_q <= warm_d;
    end
  end
  assign bus.ack = ack_q;
  assign bus.prn_out = prn_out_q;
  assign bus.ready = state_q == ST_IDLE;
  assign bus.lfsr_fault = fault_q;
  assign bus.grant_count = gc_q;
  assign bus.lfsr_enable = en_q;
endmodule

// File: tb/tb_lfsr_prn_arbiter.sv
// tb_lfsr_prn_arbiter: timeline model of the arbiter checked every cycle, plus directed scenarios
module tb_lfsr_prn_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int mode = 0;
  logic [15:0] lq;
  int tests = 0;
  int fails = 0;
  lfsr_prn_arbiter_if #(.WIDTH(16), .N_REQ(N)) bus ();
  lfsr_prn_arbiter #(.WIDTH(16), .N_REQ(N), .WARMUP_CYCLES(W)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  // Stand-in LFSR: real x^16+x^14+x^13+x^11+1 sequence, or stuck/zero fault stubs.
  always @(posedge clk) begin
    if (reset) lq <= 16'hACE1;
    else if (bus.lfsr_enable) lq <= {lq[0] ^ lq[2] ^ lq[3] ^ lq[5], lq[15:1]};
  end
  assign bus.prn = (mode == 2) ? 16'h0000 : (mode == 1) ? 16'hACE1 : lq;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  int t, idle_at, check_at, ptr;
  logic [3:0] m_ack;
  logic [15:0] m_prn_out, snap, m_gc;
  logic m_ready, m_fault, m_en;
  bit armed = 0;
  int en_cnt, ack_cnt, ready_cyc, fault_cyc, dup;
  int ack_t[$];
  int ack_i[$];
  int ack_gc[$];
  bit seen[logic [15:0]];
  always @(negedge clk) begin : model
    int w, j;
    bit found;
    logic f_next;
    if (armed) begin
      chk("ack", bus.ack, m_ack);
      chk("prn_out", bus.prn_out, m_prn_out);
      chk("ready", bus.ready, m_ready);
      chk("lfsr_fault", bus.lfsr_fault, m_fault);
      chk("grant_count", bus.grant_count, m_gc);
      chk("lfsr_enable", bus.lfsr_enable, m_en);
      if (bus.lfsr_enable) en_cnt++;
      if (bus.ready && ready_cyc < 0) ready_cyc = t;
      if (bus.lfsr_fault && fault_cyc < 0) fault_cyc = t;
      if (bus.ack != 0) begin
        ack_cnt++;
        ack_t.push_back(t);
        ack_i.push_back($clog2(bus.ack));
        ack_gc.push_back(int'(bus.grant_count));
        if (seen.exists(bus.prn_out)) dup++;
        seen[bus.prn_out] = 1;
      end
    end
    if (reset) begin
      armed = 1;
      t = 0;
      idle_at = W + 2;
      check_at = W + 1;
      ptr = 0;
      m_ack = 0; m_prn_out = 0; snap = 0; m_gc = 0;
      m_ready = 0; m_fault = 0; m_en = 0;
      en_cnt = 0; ack_cnt = 0; ready_cyc = -1; fault_cyc = -1; dup = 0;
      ack_t.delete(); ack_i.delete(); ack_gc.delete(); seen.delete();
    end else if (armed) begin
      f_next = m_fault;
      m_ack = 0;
      m_en = (t + 1 >= 1) && (t + 1 <= W);
      if (t == check_at && (bus.prn == 0 || bus.prn == snap)) f_next = 1;
      if (m_ready && bus.req != 0) begin
        found = 0; w = 0;
        for (int k = 0; k < N; k++) begin
          j = (ptr + k) % N;
          if (!found && bus.req[j]) begin found = 1; w = j; end
        end
        m_ack = 4'(1 << w);
        m_prn_out = bus.prn;
        snap = bus.prn;
        m_en = 1;
        ptr = (w + 1) % N;
        m_gc = m_gc + 16'd1;
        idle_at = t + 3;
        check_at = t + 2;
      end
      m_fault = f_next;
      t = t + 1;
      m_ready = !m_fault && t >= idle_at;
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input int m, input int n);
    reset = 1;
    mode = m;
    bus.req = '0;
    cyc(n);
    reset = 0;
  endtask
  initial begin
    bus.req = '0;
    // 1: warm-up length and first ready cycle
    do_reset(0, 3);
    cyc(40);
    chk("t1_enable_cycles", en_cnt, 32);
    chk("t1_ready_cycle", ready_cyc, 34);
    chk("t1_fault", bus.lfsr_fault, 0);
    chk("t1_ready", bus.ready, 1);
    // 2: single requester, one grant per 3 cycles
    do_reset(0, 3);
    bus.req = 4'b0001;
    for (int i = 0; i < 200 && ack_cnt < 4; i++) cyc(1);
    chk("t2_acks", ack_cnt, 4);
    if (ack_cnt >= 4) begin
      chk("t2_first_ack_cycle", ack_t[0], 35);
      chk("t2_spacing_a", ack_t[1] - ack_t[0], 3);
      chk("t2_spacing_b", ack_t[3] - ack_t[2], 3);
      for (int i = 0; i < 4; i++) begin
        chk("t2_gc", ack_gc[i], i + 1);
        chk("t2_idx", ack_i[i], 0);
      end
    end
    chk("t2_distinct", dup, 0);
    // 3: all requesters, strict rotation over 400 unique words
    do_reset(0, 3);
    bus.req = 4'b1111;
    for (int i = 0; i < 2000 && ack_cnt < 400; i++) cyc(1);
    bus.req = '0;
    cyc(3);
    chk("t3_acks", ack_cnt, 400);
    if (ack_cnt >= 8)
      for (int i = 0; i < 8; i++) chk("t3_order", ack_i[i], i % 4);
    chk("t3_distinct", dup, 0);
    chk("t3_gc", bus.grant_count, 400);
    chk("t3_fault", bus.lfsr_fault, 0);
    // 4: LFSR stuck after first grant
    do_reset(1, 3);
    bus.req = 4'b0001;
    cyc(60);
    chk("t4_acks", ack_cnt, 1);
    chk("t4_fault", bus.lfsr_fault, 1);
    chk("t4_fault_cycle", fault_cyc, 37);
    chk("t4_ready", bus.ready, 0);
    // 5: LFSR reads zero through warm-up
    do_reset(2, 3);
    bus.req = 4'b1111;
    cyc(50);
    chk("t5_acks", ack_cnt, 0);
    chk("t5_fault_cycle", fault_cyc, 34);
    chk("t5_ready_never", ready_cyc, -1);
    // 6: reset landing in the STEP cycle
    do_reset(0, 3);
    bus.req = 4'b0010;
    for (int i = 0; i < 100 && bus.ack == 0; i++) cyc(1);
    chk("t6_in_step", bus.ack, 4'b0010);
    reset = 1;
    cyc(1);
    reset = 0;
    bus.req = '0;
    cyc(40);
    chk("t6_acks", ack_cnt, 0);
    chk("t6_gc", bus.grant_count, 0);
    chk("t6_enable_cycles", en_cnt, 32);
    chk("t6_ready_cycle", ready_cyc, 34);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
